// File: rtl/debug_pkg.sv
// Shared types and constants for the debug run-control sequencer.
package debug_pkg;

  typedef enum logic [2:0] {
    ST_INITIAL = 3'd0,
    ST_RUN     = 3'd1,
    ST_HALTING = 3'd2,
    ST_HALTED  = 3'd3,
    ST_STEP    = 3'd4,
    ST_MEM     = 3'd5
  } dbg_state_t;

  localparam logic [3:0] ENABLE_ALL  = 4'b1111;
  localparam logic [3:0] ENABLE_NONE = 4'b0000;

endpackage

// File: rtl/debug_down_counter.sv
// Loadable down counter that saturates at zero and flags when it gets there.
module debug_down_counter
  import debug_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (dec && (count_r != {W{1'b0}})) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/debug_step_ctrl.sv
// Debug run-control sequencer: halt/run/step/breakpoint handling with pipeline
// drain, plus exclusive memory windows for the debug slave while halted.
module debug_step_ctrl
  import debug_pkg::*;
#(
  parameter int STEP_W       = 8,
  parameter int ADDR_W       = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              halt_req,
  input  logic              run_req,
  input  logic              step_req,
  input  logic [STEP_W-1:0] step_count,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] pc,
  input  logic              mem_req,
  input  logic              mem_done,
  output logic              enable_pc_ext,
  output logic [3:0]        enable_ext,
  output logic              halted,
  output logic              bp_hit,
  output logic              mem_grant
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  dbg_state_t        state_r;
  dbg_state_t        state_next;
  logic              first_r;
  logic              running_s;
  logic              running_next_s;
  logic              bp_match_s;
  logic              drain_zero_s;
  logic              step_zero_s;
  logic [STEP_W-1:0] step_load_s;

  assign running_s      = (state_r == ST_RUN) || (state_r == ST_STEP);
  assign running_next_s = (state_next == ST_RUN) || (state_next == ST_STEP);
  // first_r masks the compare on the first running cycle so a resume from the breakpoint PC advances.
  assign bp_match_s     = bp_en && running_s && !first_r && (pc == bp_addr);
  assign step_load_s    = (step_count == {STEP_W{1'b0}}) ? {STEP_W{1'b0}}
                                                         : step_count - STEP_W'(1);

  debug_down_counter #(.W(DRAIN_W)) u_drain_cnt (
    .clk        (CLK),
    .rst_n      (RST),
    .load       ((state_next == ST_HALTING) && (state_r != ST_HALTING)),
    .dec        (state_r == ST_HALTING),
    .load_value (DRAIN_W'(DRAIN_CYCLES - 1)),
    .zero       (drain_zero_s)
  );

  debug_down_counter #(.W(STEP_W)) u_step_cnt (
    .clk        (CLK),
    .rst_n      (RST),
    .load       ((state_next == ST_STEP) && (state_r != ST_STEP)),
    .dec        (state_r == ST_STEP),
    .load_value (step_load_s),
    .zero       (step_zero_s)
  );

  // Next-state selection; from idle states mem_req beats step_req beats run_req.
  always_comb begin
    state_next = state_r;
    case (state_r)
      ST_INITIAL, ST_HALTED: begin
        if (mem_req)       state_next = ST_MEM;
        else if (step_req) state_next = ST_STEP;
        else if (run_req)  state_next = ST_RUN;
        else               state_next = state_r;
      end
      ST_RUN: begin
        if (halt_req || bp_match_s) state_next = ST_HALTING;
        else                        state_next = ST_RUN;
      end
      ST_HALTING: begin
        if (drain_zero_s) state_next = ST_HALTED;
        else              state_next = ST_HALTING;
      end
      ST_STEP: begin
        if (halt_req || bp_match_s || step_zero_s) state_next = ST_HALTING;
        else                                       state_next = ST_STEP;
      end
      ST_MEM: begin
        if (mem_done) state_next = ST_HALTED;
        else          state_next = ST_MEM;
      end
      default: state_next = ST_INITIAL;
    endcase
  end

  // State register and outputs decoded from the next state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r       <= ST_INITIAL;
      first_r       <= 1'b0;
      enable_pc_ext <= 1'b0;
      enable_ext    <= ENABLE_NONE;
      halted        <= 1'b1;
      bp_hit        <= 1'b0;
      mem_grant     <= 1'b0;
    end else begin
      state_r       <= state_next;
      first_r       <= running_next_s && !running_s;
      enable_pc_ext <= running_next_s;
      enable_ext    <= (running_next_s || (state_next == ST_HALTING)) ? ENABLE_ALL : ENABLE_NONE;
      halted        <= (state_next == ST_INITIAL) || (state_next == ST_HALTED) ||
                       (state_next == ST_MEM);
      bp_hit        <= bp_match_s;
      mem_grant     <= (state_next == ST_MEM);
    end
  end

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Directed self-checking bench for debug_step_ctrl (DRAIN_CYCLES=2).
module tb_debug_step_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        halt_req = 1'b0, run_req = 1'b0, step_req = 1'b0;
  logic [7:0]  step_count = 8'd0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = 32'd0, pc = 32'd0;
  logic        mem_req = 1'b0, mem_done = 1'b0;
  logic        enable_pc_ext, halted, bp_hit, mem_grant;
  logic [3:0]  enable_ext;

  int checks = 0;
  int failures = 0;

  // Output vector layout: {enable_pc_ext, enable_ext[3:0], halted, mem_grant, bp_hit}
  localparam logic [7:0] O_RUN  = 8'b1111_1000;
  localparam logic [7:0] O_DRN  = 8'b0111_1000;
  localparam logic [7:0] O_HLT  = 8'b0000_0100;
  localparam logic [7:0] O_MEM  = 8'b0000_0110;
  localparam logic [7:0] O_BPH  = 8'b0111_1001;

  debug_step_ctrl #(.STEP_W(8), .ADDR_W(32), .DRAIN_CYCLES(2)) dut (
    .CLK(CLK), .RST(RST), .halt_req(halt_req), .run_req(run_req), .step_req(step_req),
    .step_count(step_count), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .mem_req(mem_req), .mem_done(mem_done), .enable_pc_ext(enable_pc_ext),
    .enable_ext(enable_ext), .halted(halted), .bp_hit(bp_hit), .mem_grant(mem_grant)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] outs();
    return {enable_pc_ext, enable_ext, halted, mem_grant, bp_hit};
  endfunction

  task automatic test_reset();
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++; if (outs() !== O_HLT) begin failures++; $display("FAIL reset_hold%0d got=%b exp=%b", i, outs(), O_HLT); end
    end
    RST = 1'b1;
    @(negedge CLK);
    checks++; if (outs() !== O_HLT) begin failures++; $display("FAIL initial got=%b exp=%b", outs(), O_HLT); end
    run_req = 1'b1; @(negedge CLK); run_req = 1'b0;
    checks++; if (outs() !== O_RUN) begin failures++; $display("FAIL run_p1 got=%b exp=%b", outs(), O_RUN); end
    @(negedge CLK);
    checks++; if (outs() !== O_RUN) begin failures++; $display("FAIL run_p2 got=%b exp=%b", outs(), O_RUN); end
  endtask

  task automatic test_halt_drain();
    halt_req = 1'b1; @(negedge CLK); halt_req = 1'b0;
    checks++; if (outs() !== O_DRN) begin failures++; $display("FAIL drain_p1 got=%b exp=%b", outs(), O_DRN); end
    halt_req = 1'b1; @(negedge CLK); halt_req = 1'b0;
    checks++; if (outs() !== O_DRN) begin failures++; $display("FAIL drain_p2 got=%b exp=%b", outs(), O_DRN); end
    @(negedge CLK);
    checks++; if (outs() !== O_HLT) begin failures++; $display("FAIL drain_p3 got=%b exp=%b", outs(), O_HLT); end
    @(negedge CLK);
    checks++; if (outs() !== O_HLT) begin failures++; $display("FAIL halted_stays got=%b exp=%b", outs(), O_HLT); end
  endtask

  task automatic test_step(input logic [7:0] cnt, input int n);
    step_count = cnt; step_req = 1'b1; @(negedge CLK); step_req = 1'b0; step_count = 8'd0;
    for (int i = 0; i < n; i++) begin
      checks++; if (outs() !== O_RUN) begin failures++; $display("FAIL step%0d_cyc%0d got=%b exp=%b", cnt, i, outs(), O_RUN); end
      @(negedge CLK);
    end
    checks++; if (outs() !== O_DRN) begin failures++; $display("FAIL step%0d_drain1 got=%b exp=%b", cnt, outs(), O_DRN); end
    @(negedge CLK);
    checks++; if (outs() !== O_DRN) begin failures++; $display("FAIL step%0d_drain2 got=%b exp=%b", cnt, outs(), O_DRN); end
    @(negedge CLK);
    checks++; if (outs() !== O_HLT) begin failures++; $display("FAIL step%0d_halted got=%b exp=%b", cnt, outs(), O_HLT); end
  endtask

  task automatic test_breakpoint();
    int hits;
    hits = 0;
    pc = 32'd0; bp_addr = 32'h0000_0040; bp_en = 1'b1;
    run_req = 1'b1; @(negedge CLK); run_req = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      pc = 32'(k * 4);
      @(negedge CLK);
      if (bp_hit === 1'b1) hits++;
    end
    checks++; if (outs() !== O_BPH) begin failures++; $display("FAIL bp_halt got=%b exp=%b", outs(), O_BPH); end
    checks++; if (hits !== 1) begin failures++; $display("FAIL bp_hit_count got=%0d exp=%0d", hits, 1); end
    @(negedge CLK);
    checks++; if (outs() !== O_DRN) begin failures++; $display("FAIL bp_pulse_once got=%b exp=%b", outs(), O_DRN); end
    @(negedge CLK);
    checks++; if (outs() !== O_HLT) begin failures++; $display("FAIL bp_halted got=%b exp=%b", outs(), O_HLT); end
    run_req = 1'b1; @(negedge CLK); run_req = 1'b0;
    checks++; if (outs() !== O_RUN) begin failures++; $display("FAIL resume_p1 got=%b exp=%b", outs(), O_RUN); end
    pc = 32'h0000_0044;
    @(negedge CLK);
    checks++; if (outs() !== O_RUN) begin failures++; $display("FAIL resume_no_rehit got=%b exp=%b", outs(), O_RUN); end
    bp_en = 1'b0;
    halt_req = 1'b1; @(negedge CLK); halt_req = 1'b0;
    @(negedge CLK); @(negedge CLK);
    checks++; if (outs() !== O_HLT) begin failures++; $display("FAIL bp_rehalt got=%b exp=%b", outs(), O_HLT); end
  endtask

  task automatic test_mem_window();
    mem_req = 1'b1; step_req = 1'b1; step_count = 8'd5;
    @(negedge CLK); step_req = 1'b0;
    checks++; if (outs() !== O_MEM) begin failures++; $display("FAIL mem_wins got=%b exp=%b", outs(), O_MEM); end
    run_req = 1'b1; halt_req = 1'b1; @(negedge CLK); run_req = 1'b0; halt_req = 1'b0;
    checks++; if (outs() !== O_MEM) begin failures++; $display("FAIL mem_ignores_req got=%b exp=%b", outs(), O_MEM); end
    mem_done = 1'b1; @(negedge CLK); mem_done = 1'b0; mem_req = 1'b0;
    checks++; if (outs() !== O_HLT) begin failures++; $display("FAIL mem_grant_drop got=%b exp=%b", outs(), O_HLT); end
    @(negedge CLK); @(negedge CLK);
    checks++; if (outs() !== O_HLT) begin failures++; $display("FAIL mem_no_queued_step got=%b exp=%b", outs(), O_HLT); end
    mem_done = 1'b1; @(negedge CLK); mem_done = 1'b0;
    checks++; if (outs() !== O_HLT) begin failures++; $display("FAIL stray_mem_done got=%b exp=%b", outs(), O_HLT); end
  endtask

  task automatic test_mid_mem_reset();
    mem_req = 1'b1; @(negedge CLK);
    checks++; if (outs() !== O_MEM) begin failures++; $display("FAIL mem_again got=%b exp=%b", outs(), O_MEM); end
    #2 RST = 1'b0;
    #1;
    checks++; if (outs() !== O_HLT) begin failures++; $display("FAIL async_reset got=%b exp=%b", outs(), O_HLT); end
    mem_req = 1'b0;
    @(negedge CLK); @(negedge CLK); RST = 1'b1;
    @(negedge CLK);
    checks++; if (outs() !== O_HLT) begin failures++; $display("FAIL post_reset got=%b exp=%b", outs(), O_HLT); end
    run_req = 1'b1; @(negedge CLK); run_req = 1'b0;
    checks++; if (outs() !== O_RUN) begin failures++; $display("FAIL post_reset_run got=%b exp=%b", outs(), O_RUN); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_halt_drain();
    test_step(8'd3, 3);
    test_step(8'd0, 1);
    test_breakpoint();
    test_mem_window();
    test_mid_mem_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
